// File: rtl/mmio_uart_tx_pkg.sv
// Shared types for the MMIO UART transmitter.
// Bus control bundle, register offsets, STATUS layout, FSM states.
package mmio_uart_tx_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_width_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] value;
    mem_width_t      width;
    logic            enable;
  } mem_write_control_t;

  localparam logic [3:0] UART_TXDATA_OFFSET  = 4'h0;
  localparam logic [3:0] UART_STATUS_OFFSET  = 4'h4;
  localparam logic [3:0] UART_DIVISOR_OFFSET = 4'h8;

  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_EMPTY_BIT = 2;
  localparam int STATUS_COUNT_LSB = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } uart_tx_state_t;

  typedef enum logic {
    ACC_IDLE    = 1'b0,
    ACC_RELEASE = 1'b1
  } mmio_acc_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two depth, show-ahead read port.
// Ports: clock/reset, push+push_data, pop->pop_data, full, empty, count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = count == CW'(DEPTH);
  assign empty    = count == '0;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: TXDATA/STATUS/DIVISOR window, TX FIFO, 8N1 line.
// Ports: clock, reset, memory_mapped_io_control/r_data/write_complete, uart_tx, tx_idle.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0001_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd4
) (
  input  logic               clock,
  input  logic               reset,
  input  mem_write_control_t memory_mapped_io_control,
  output logic [XLEN-1:0]    memory_mapped_io_r_data,
  output logic               memory_mapped_io_write_complete,
  output logic               uart_tx,
  output logic               tx_idle
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  mem_write_control_t ctl;
  logic               in_win;
  logic [3:0]         off;
  logic               hit_txdata;
  logic               hit_status;
  logic               hit_div;

  assign ctl        = memory_mapped_io_control;
  assign in_win     = ctl.addr[XLEN-1:4] == BASE_ADDR[XLEN-1:4];
  assign off        = ctl.addr[3:0];
  assign hit_txdata = in_win && (off == UART_TXDATA_OFFSET);
  assign hit_status = in_win && (off == UART_STATUS_OFFSET);
  assign hit_div    = in_win && (off == UART_DIVISOR_OFFSET);

  logic unused_value_hi;
  assign unused_value_hi = ^ctl.value[XLEN-1:16];

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_data;
  logic          fifo_push;
  logic          pop;

  mmio_acc_state_t acc_q;
  mmio_acc_state_t acc_d;
  logic            accept;
  logic            wc_q;
  logic [15:0]     divisor_q;

  uart_tx_state_t tx_q;
  uart_tx_state_t tx_d;
  logic [15:0]    div_lat_q;
  logic [15:0]    div_lat_d;
  logic [15:0]    cnt_q;
  logic [15:0]    cnt_d;
  logic [7:0]     shift_q;
  logic [7:0]     shift_d;
  logic [2:0]     bit_q;
  logic [2:0]     bit_d;
  logic           bit_end;
  logic           line;
  logic           busy;
  logic [7:0]     status;

  // Full-FIFO TXDATA writes are held off by withholding the accept.
  always_comb begin
    acc_d  = acc_q;
    accept = 1'b0;
    unique case (acc_q)
      ACC_IDLE: begin
        if (ctl.enable && in_win && (!hit_txdata || !fifo_full)) begin
          accept = 1'b1;
          acc_d  = ACC_RELEASE;
        end
      end
      ACC_RELEASE: begin
        if (!ctl.enable) begin
          acc_d = ACC_IDLE;
        end
      end
      default: acc_d = ACC_IDLE;
    endcase
  end

  assign fifo_push = accept && hit_txdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q     <= ACC_IDLE;
      wc_q      <= 1'b0;
      divisor_q <= DEFAULT_DIVISOR;
    end else begin
      acc_q <= acc_d;
      wc_q  <= accept;
      if (accept && hit_div && (ctl.width == MEM_WORD)) begin
        divisor_q <= (ctl.value[15:0] == 16'd0) ? 16'd1 : ctl.value[15:0];
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (ctl.value[7:0]),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // cnt counts down from div-1; the divisor is frozen per frame.
  assign bit_end = cnt_q == 16'd0;

  always_comb begin
    tx_d      = tx_q;
    div_lat_d = div_lat_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    pop       = 1'b0;
    line      = 1'b1;
    unique case (tx_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_data;
          div_lat_d = divisor_q;
          cnt_d     = divisor_q - 16'd1;
          bit_d     = '0;
          tx_d      = TX_START;
        end
      end
      TX_START: begin
        line = 1'b0;
        if (bit_end) begin
          cnt_d = div_lat_q - 16'd1;
          tx_d  = TX_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        line = shift_q[0];
        if (bit_end) begin
          cnt_d   = div_lat_q - 16'd1;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            tx_d = TX_STOP;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          tx_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: tx_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_q      <= TX_IDLE;
      div_lat_q <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      bit_q     <= '0;
    end else begin
      tx_q      <= tx_d;
      div_lat_q <= div_lat_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
    end
  end

  assign busy = tx_q != TX_IDLE;

  always_comb begin
    status                              = '0;
    status[STATUS_BUSY_BIT]             = busy;
    status[STATUS_FULL_BIT]             = fifo_full;
    status[STATUS_EMPTY_BIT]            = fifo_empty;
    status[STATUS_COUNT_LSB +: 4]       = 4'(fifo_count);
  end

  always_comb begin
    memory_mapped_io_r_data = '0;
    unique case (1'b1)
      hit_status: memory_mapped_io_r_data = XLEN'(status);
      hit_div:    memory_mapped_io_r_data = XLEN'(divisor_q);
      default:    memory_mapped_io_r_data = '0;
    endcase
  end

  assign memory_mapped_io_write_complete = wc_q;
  assign uart_tx                         = line;
  assign tx_idle                         = fifo_empty && !busy;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed and random MMIO writes,
// line decoded by a frame monitor and compared with a byte queue.
module tb_mmio_uart_tx;
  import mmio_uart_tx_pkg::*;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_DV = BASE + 32'h8;
  localparam logic [31:0] A_UN = BASE + 32'hC;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  mem_write_control_t ctl;
  logic [XLEN-1:0]    r_data;
  logic               wc;
  logic               uart_tx;
  logic               tx_idle;

  int         checks = 0;
  int         errors = 0;
  int         exp_div = 4;
  int         rx_frames = 0;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  mmio_uart_tx #(
    .BASE_ADDR       (BASE),
    .FIFO_DEPTH      (4),
    .DEFAULT_DIVISOR (16'd4)
  ) dut (
    .clock                           (clock),
    .reset                           (reset),
    .memory_mapped_io_control        (ctl),
    .memory_mapped_io_r_data         (r_data),
    .memory_mapped_io_write_complete (wc),
    .uart_tx                         (uart_tx),
    .tx_idle                         (tx_idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    ctl.addr   = a;
    ctl.enable = 1'b0;
    #1;
    d = r_data;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v,
                    input mem_width_t w, output int lat);
    ctl.addr   = a;
    ctl.value  = v;
    ctl.width  = w;
    ctl.enable = 1'b1;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clock);
      if (wc) begin
        lat = i;
        break;
      end
    end
    ctl.enable = 1'b0;
    @(negedge clock);
    chk("wc_one_cycle", wc, 0);
  endtask

  task automatic tx_byte(input logic [7:0] b, output int lat);
    wr(A_TX, {$urandom_range(0, 255), 24'h0} | 32'(b), MEM_BYTE, lat);
    if (lat > 0) exp_q.push_back(b);
  endtask

  task automatic wait_idle(input string tag);
    int stable;
    stable = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (tx_idle) stable++;
      else stable = 0;
      if (stable >= 3) break;
    end
    chk({tag, "_idle"}, stable >= 3, 1);
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // Frame monitor: start bit, 8 data bits LSB first, stop bit, each
  // exactly exp_div samples, followed by at least one idle sample.
  initial begin : monitor
    logic       samp[$];
    int         d;
    logic       aborted;
    logic       good;
    logic [7:0] rb;
    logic [8:0] expb;
    forever begin
      @(negedge clock);
      if (!reset && uart_tx === 1'b0) begin
        d = exp_div;
        samp.delete();
        samp.push_back(uart_tx);
        aborted = 1'b0;
        for (int t = 1; t < 10 * d; t++) begin
          @(negedge clock);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          samp.push_back(uart_tx);
        end
        if (!aborted) begin
          good = 1'b1;
          for (int b = 0; b < 10; b++)
            for (int c = 0; c < d; c++)
              if (samp[b*d+c] !== samp[b*d]) good = 1'b0;
          for (int b = 0; b < 8; b++) rb[b] = samp[(b+1)*d];
          chk("frame_bit_widths", good, 1);
          chk("frame_stop_bit", samp[9*d], 1);
          if (exp_q.size() > 0) expb = {1'b0, exp_q.pop_front()};
          else expb = 9'h100;
          chk("frame_byte", {1'b0, rb}, expb);
          rx_frames++;
          @(negedge clock);
          if (!reset) chk("frame_gap_idle", uart_tx, 1);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] d;
    int          lat;
    int          lats[6];
    int          pulses;
    int          frames0;
    int          n;
    int          dv;

    ctl   = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    chk("rst_wc", wc, 0);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_tx_idle", tx_idle, 1);
    rd(A_ST, d);
    chk("rst_status", d, 32'h04);
    rd(A_DV, d);
    chk("rst_divisor", d, 32'd4);
    rd(A_UN, d);
    chk("rst_unmapped", d, 0);

    // Single frame 0x55 at divisor 4
    tx_byte(8'h55, lat);
    chk("t1_lat", lat, 1);
    chk("t1_start_low", uart_tx, 0);
    chk("t1_tx_idle", tx_idle, 0);
    rd(A_ST, d);
    chk("t1_busy", d[0], 1);
    wait_idle("t1");
    rd(A_ST, d);
    chk("t1_status_after", d, 32'h04);
    chk("t1_frames", rx_frames, 1);

    // Six back-to-back writes into a depth-4 FIFO
    for (int i = 0; i < 6; i++) begin
      tx_byte(8'(i + 1), lats[i]);
    end
    for (int i = 0; i < 5; i++) chk("b2b_lat_prompt", lats[i], 1);
    chk("b2b_lat6_delayed", lats[5] > 10, 1);
    wait_idle("b2b");
    chk("b2b_frames", rx_frames, 7);

    // Divisor programming
    wr(A_DV, 32'd2, MEM_WORD, lat);
    chk("div2_lat", lat, 1);
    rd(A_DV, d);
    chk("div2_read", d, 2);
    exp_div = 2;
    tx_byte(8'hA5, lat);
    wait_idle("div2");
    wr(A_DV, 32'd0, MEM_WORD, lat);
    rd(A_DV, d);
    chk("div0_reads_1", d, 1);
    wr(A_DV, 32'd7, MEM_BYTE, lat);
    chk("div_byte_lat", lat, 1);
    rd(A_DV, d);
    chk("div_byte_ignored", d, 1);
    exp_div = 1;
    tx_byte(8'($urandom_range(0, 255)), lat);
    wait_idle("div1");

    // Random divisors and bursts
    for (int r = 0; r < 5; r++) begin
      dv = $urandom_range(1, 6);
      wr(A_DV, {16'($urandom_range(0, 65535)), 16'(dv)}, MEM_WORD, lat);
      rd(A_DV, d);
      chk("rand_div", d, 32'(dv));
      exp_div = dv;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        tx_byte(8'($urandom_range(0, 255)), lat);
        chk("rand_ack", lat > 0, 1);
      end
      wait_idle("rand");
    end

    // Enable held high for ten cycles
    wr(A_DV, 32'd4, MEM_WORD, lat);
    exp_div = 4;
    frames0    = rx_frames;
    ctl.addr   = A_TX;
    ctl.value  = 32'h3C;
    ctl.width  = MEM_WORD;
    ctl.enable = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (wc) pulses++;
    end
    ctl.enable = 1'b0;
    exp_q.push_back(8'h3C);
    chk("hold_pulses", pulses, 1);
    @(negedge clock);
    rd(A_ST, d);
    chk("hold_status", d, 32'h05);
    wait_idle("hold");
    chk("hold_frames", rx_frames - frames0, 1);

    // Out-of-window and unmapped accesses
    frames0    = rx_frames;
    ctl.addr   = 32'h0002_0000;
    ctl.value  = 32'h77;
    ctl.width  = MEM_WORD;
    ctl.enable = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (wc) pulses++;
    end
    #1;
    chk("oow_rdata", r_data, 0);
    ctl.enable = 1'b0;
    chk("oow_no_complete", pulses, 0);
    rd(32'h0002_0004, d);
    chk("oow_status_alias", d, 0);
    rd(A_ST, d);
    chk("oow_status", d, 32'h04);
    wr(A_UN, 32'h12, MEM_WORD, lat);
    chk("unmapped_lat", lat, 1);
    rd(A_UN, d);
    chk("unmapped_read", d, 0);
    wr(A_ST, 32'hFF, MEM_WORD, lat);
    chk("status_wr_lat", lat, 1);
    rd(A_ST, d);
    chk("status_wr_ignored", d, 32'h04);
    rd(A_DV, d);
    chk("unmapped_div", d, 4);
    repeat (20) @(negedge clock);
    chk("oow_frames", rx_frames, frames0);

    // Reset in the middle of a frame with bytes queued
    wr(A_DV, 32'd3, MEM_WORD, lat);
    exp_div = 3;
    frames0 = rx_frames;
    for (int i = 0; i < 3; i++) tx_byte(8'($urandom_range(0, 255)), lat);
    repeat (4) @(negedge clock);
    exp_q.delete();
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_uart_tx", uart_tx, 1);
    chk("mid_rst_wc", wc, 0);
    chk("mid_rst_tx_idle", tx_idle, 1);
    rd(A_ST, d);
    chk("mid_rst_status", d, 32'h04);
    rd(A_DV, d);
    chk("mid_rst_div", d, 4);
    @(negedge clock);
    reset = 1'b0;
    exp_div = 4;
    repeat (100) @(negedge clock);
    chk("post_rst_frames", rx_frames, frames0);
    chk("post_rst_line", uart_tx, 1);
    chk("post_rst_idle", tx_idle, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
